// File: rtl/seg7_decimal_display.sv
// Multi-cycle binary-to-BCD (double dabble) display stage: accepts a 16-bit value, shows it on four active-low 7-seg digits.
// Latency 17 clocks from accept to display; wr_ready stays low while converting and new requests are refused, not queued.
module seg7_decimal_display #(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        blank,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [19:0] bcd_adj;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        ovf_q, ovf_d;
  logic        shown_q, shown_d;
  logic [27:0] hex_q, hex_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Nibble-local add-3; no carry crosses a digit boundary.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                     : bcd_q[i*4 +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    shown_d  = shown_q;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          bin_d   = wr_data;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == 5'd15) state_d = LATCH;
      end
      LATCH: begin
        digits_d = bcd_q[15:0];
        ovf_d    = |bcd_q[19:16];
        shown_d  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display image follows the next-state digits so a new value appears on the LATCH edge.
  always_comb begin
    logic [3:0] d3, d2, d1, d0;
    logic       lz3, lz2, lz1;
    d3  = digits_d[15:12];
    d2  = digits_d[11:8];
    d1  = digits_d[7:4];
    d0  = digits_d[3:0];
    lz3 = LZ_BLANK && (d3 == 4'd0);
    lz2 = lz3 && (d2 == 4'd0);
    lz1 = lz2 && (d1 == 4'd0);
    if (blank || !shown_d) begin
      hex_d = {4{7'h7F}};
    end else if (ovf_d) begin
      hex_d = {4{7'h3F}};
    end else begin
      hex_d = {lz3 ? 7'h7F : seg_encode(d3),
               lz2 ? 7'h7F : seg_encode(d2),
               lz1 ? 7'h7F : seg_encode(d1),
               seg_encode(d0)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      shown_q  <= 1'b0;
      hex_q    <= {4{7'h7F}};
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      shown_q  <= shown_d;
      hex_q    <= hex_d;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = ~wr_ready;
  assign ovf      = ovf_q;
  assign hex3     = hex_q[27:21];
  assign hex2     = hex_q[20:14];
  assign hex1     = hex_q[13:7];
  assign hex0     = hex_q[6:0];

endmodule

// File: tb/tb_seg7_decimal_display.sv
// Directed bench for seg7_decimal_display: one instance with leading-zero blanking, one without.
module tb_seg7_decimal_display;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        blank;
  logic        wr_ready_a, busy_a, ovf_a;
  logic [6:0]  hex3_a, hex2_a, hex1_a, hex0_a;
  logic        wr_ready_b, busy_b, ovf_b;
  logic [6:0]  hex3_b, hex2_b, hex1_b, hex0_b;
  logic [27:0] hex_a, hex_b;

  int total = 0;
  int bad   = 0;

  seg7_decimal_display #(.LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready_a), .blank(blank),
    .hex3(hex3_a), .hex2(hex2_a), .hex1(hex1_a), .hex0(hex0_a),
    .ovf(ovf_a), .busy(busy_a)
  );

  seg7_decimal_display #(.LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready_b), .blank(blank),
    .hex3(hex3_b), .hex2(hex2_b), .hex1(hex1_b), .hex0(hex0_b),
    .ovf(ovf_b), .busy(busy_b)
  );

  assign hex_a = {hex3_a, hex2_a, hex1_a, hex0_a};
  assign hex_b = {hex3_b, hex2_b, hex1_b, hex0_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a value and hold wr_valid over exactly one rising edge (edge N); returns at N+1ns.
  task automatic send(input logic [15:0] v);
    check("ready_before_send", {31'd0, wr_ready_a}, 32'd1);
    wr_data  = v;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  // Called at N+1ns: old image must persist through N+16, new image at N+17.
  task automatic expect_result(input string tag, input logic [27:0] prev,
                               input logic [27:0] exp, input logic exp_ovf);
    repeat (16) @(posedge clk);
    #1;
    check({tag, "_hold"}, {4'd0, hex_a}, {4'd0, prev});
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_hex"}, {4'd0, hex_a}, {4'd0, exp});
    check({tag, "_ovf"}, {31'd0, ovf_a}, {31'd0, exp_ovf});
    check({tag, "_ready"}, {31'd0, wr_ready_a}, 32'd1);
  endtask

  localparam logic [27:0] ALL_OFF = {4{7'h7F}};
  localparam logic [27:0] DASHES  = {4{7'h3F}};
  localparam logic [27:0] H1234   = {7'h79, 7'h24, 7'h30, 7'h19};

  initial begin
    int hi_cnt;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'd0;
    blank    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", {4'd0, hex_a}, {4'd0, ALL_OFF});
    check("rst_ready", {31'd0, wr_ready_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'd1234);
    expect_result("v1234", ALL_OFF, H1234, 1'b0);
    check("v1234_nolz", {4'd0, hex_b}, {4'd0, H1234});

    send(16'd7);
    expect_result("v7", H1234, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0);
    check("v7_nolz", {4'd0, hex_b}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h78});

    send(16'd0);
    expect_result("v0", {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);

    send(16'd9999);
    expect_result("v9999", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4{7'h10}}, 1'b0);

    send(16'd10000);
    expect_result("v10000", {4{7'h10}}, DASHES, 1'b1);

    send(16'd65535);
    expect_result("v65535", DASHES, DASHES, 1'b1);

    send(16'd42);
    expect_result("v42", DASHES, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0);

    // Back-to-back: 6 is offered continuously while 5 converts.
    send(16'd5);
    wr_data  = 16'd6;
    wr_valid = 1'b1;
    hi_cnt   = 0;
    for (int i = 0; i < 17; i++) begin
      if (wr_ready_a) hi_cnt++;
      @(posedge clk);
      #1;
    end
    check("b2b_ready_low", hi_cnt, 0);
    check("b2b_hex5", {4'd0, hex_a}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    check("b2b_ready_n17", {31'd0, wr_ready_a}, 32'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check("b2b_accept6", {31'd0, busy_a}, 32'd1);
    expect_result("v6", {7'h7F, 7'h7F, 7'h7F, 7'h12}, {7'h7F, 7'h7F, 7'h7F, 7'h02}, 1'b0);

    // Reset in the middle of converting 8888.
    send(16'd8888);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_hex", {4'd0, hex_a}, {4'd0, ALL_OFF});
    check("midrst_ready", {31'd0, wr_ready_a}, 32'd1);
    check("midrst_ovf", {31'd0, ovf_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_lost", {4'd0, hex_a}, {4'd0, ALL_OFF});
    send(16'd321);
    expect_result("v321", ALL_OFF, {7'h7F, 7'h30, 7'h24, 7'h79}, 1'b0);

    // Blank input.
    send(16'd1234);
    expect_result("v1234b", {7'h7F, 7'h30, 7'h24, 7'h79}, H1234, 1'b0);
    blank = 1'b1;
    @(posedge clk);
    #1;
    check("blank_on", {4'd0, hex_a}, {4'd0, ALL_OFF});
    send(16'd56);
    expect_result("v56_blank", ALL_OFF, ALL_OFF, 1'b0);
    blank = 1'b0;
    @(posedge clk);
    #1;
    check("blank_off", {4'd0, hex_a}, {4'd0, 7'h7F, 7'h7F, 7'h12, 7'h02});
    check("blank_off_nolz", {4'd0, hex_b}, {4'd0, 7'h40, 7'h40, 7'h12, 7'h02});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
